// File: rtl/grey_sobel_edge.sv
// Streaming 3x3 Sobel edge detector: 8-bit grey in, saturated |Gx|+|Gy| out, 3-cycle latency.
// Define SOBEL_BIN_EN to enable the thresholded binary edge output and binary RGB565 replica.
module grey_sobel_edge #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_sof,
  input  logic [7:0]  i_grey8b,
  input  logic [7:0]  i_thresh,
  output logic        o_valid,
  output logic        o_sof,
  output logic [7:0]  o_mag8b,
  output logic        o_edge_bin,
  output logic [15:0] o_greydata
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  // ---------------------------------------------------------------------------
  // S1: raster position, line buffers, window
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          v1_q, sof1_q, mask1_q;
  logic [7:0]    win_q [3][3];
  logic [7:0]    lb0_q [IMG_W];
  logic [7:0]    lb1_q [IMG_W];

  // A qualified sof pins the current pixel to (0,0) whatever the counters say.
  always_comb begin
    cur_col = i_sof ? '0 : col_q;
    cur_row = i_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (i_valid) begin
      if (cur_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  // Line buffers are never cleared; border masking hides stale contents.
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      lb0_q[cur_col] <= lb1_q[cur_col];
      lb1_q[cur_col] <= i_grey8b;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      v1_q    <= 1'b0;
      sof1_q  <= 1'b0;
      mask1_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      v1_q   <= i_valid;
      sof1_q <= i_valid & i_sof;
      if (i_valid) begin
        mask1_q <= (cur_col < CW'(2)) || (cur_row < RW'(2));
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 2; c++) begin
            win_q[r][c] <= win_q[r][c+1];
          end
        end
        win_q[0][2] <= lb0_q[cur_col];
        win_q[1][2] <= lb1_q[cur_col];
        win_q[2][2] <= i_grey8b;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: gradients
  // ---------------------------------------------------------------------------
  function automatic logic [9:0] tri_sum(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  logic signed [10:0] gx_d, gy_d, gx_q, gy_q;
  logic               v2_q, sof2_q, mask2_q;

  always_comb begin
    gx_d = $signed({1'b0, tri_sum(win_q[0][2], win_q[1][2], win_q[2][2])})
         - $signed({1'b0, tri_sum(win_q[0][0], win_q[1][0], win_q[2][0])});
    gy_d = $signed({1'b0, tri_sum(win_q[2][0], win_q[2][1], win_q[2][2])})
         - $signed({1'b0, tri_sum(win_q[0][0], win_q[0][1], win_q[0][2])});
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gx_q    <= '0;
      gy_q    <= '0;
      v2_q    <= 1'b0;
      sof2_q  <= 1'b0;
      mask2_q <= 1'b0;
    end else begin
      v2_q   <= v1_q;
      sof2_q <= sof1_q;
      if (v1_q) begin
        gx_q    <= gx_d;
        gy_q    <= gy_d;
        mask2_q <= mask1_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: magnitude, saturation, threshold, outputs
  // ---------------------------------------------------------------------------
  logic [10:0] abs_x, abs_y, mag_sum;
  logic [7:0]  mag_d, mag_q;
  logic        edge_d, edge_q;
  logic [15:0] grey_d, grey_q;
  logic        valid_q, sof_q;

  always_comb begin
    abs_x   = gx_q[10] ? $unsigned(-gx_q) : $unsigned(gx_q);
    abs_y   = gy_q[10] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag_sum = abs_x + abs_y;
    mag_d   = mask2_q ? 8'h00 : ((mag_sum > 11'd255) ? 8'hFF : mag_sum[7:0]);
`ifdef SOBEL_BIN_EN
    edge_d  = (mag_d > i_thresh);
    grey_d  = {16{edge_d}};
`else
    edge_d  = 1'b0;
    grey_d  = {mag_d[7:3], mag_d[7:2], mag_d[7:3]};
`endif
  end

`ifndef SOBEL_BIN_EN
  logic unused_thresh;
  assign unused_thresh = ^i_thresh;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      mag_q   <= '0;
      edge_q  <= 1'b0;
      grey_q  <= '0;
    end else begin
      valid_q <= v2_q;
      sof_q   <= sof2_q;
      if (v2_q) begin
        mag_q  <= mag_d;
        edge_q <= edge_d;
        grey_q <= grey_d;
      end
    end
  end

  assign o_valid    = valid_q;
  assign o_sof      = sof_q;
  assign o_mag8b    = mag_q;
  assign o_edge_bin = edge_q;
  assign o_greydata = grey_q;

endmodule

// File: tb/tb_grey_sobel_edge.sv
// Bench for grey_sobel_edge: directed and random frames against a frame-array Sobel model.
module tb_grey_sobel_edge;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic        sof = 1'b0;
  logic [7:0]  grey = 8'd0;
  logic [7:0]  thresh = 8'd0;
  logic        o_valid, o_sof, o_edge_bin;
  logic [7:0]  o_mag8b;
  logic [15:0] o_greydata;

  grey_sobel_edge #(.IMG_W(W), .IMG_H(H)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (valid),
    .i_sof     (sof),
    .i_grey8b  (grey),
    .i_thresh  (thresh),
    .o_valid   (o_valid),
    .o_sof     (o_sof),
    .o_mag8b   (o_mag8b),
    .o_edge_bin(o_edge_bin),
    .o_greydata(o_greydata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  mag;
    logic        edge_bin;
    logic [15:0] grey;
    logic        sof;
    bit          pin_en;
    logic [7:0]  pin;
  } exp_t;

  exp_t q[$];
  bit   vin_hist [0:16383];
  int   img [H][W];
  int   mcol = 0, mrow = 0;
  int   errors = 0, checks = 0;
  bit   chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sobel straight from the frame as stored by raster position.
  function automatic int ref_mag(input int r, input int c);
    int gx, gy, m;
    if (r < 2 || c < 2) return 0;
    gx = (img[r-2][c] + 2 * img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2 * img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2 * img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2 * img[r-2][c-1] + img[r-2][c]);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  task automatic send(input int px, input bit s, input bit pin_en, input int pin);
    exp_t e;
    logic [7:0] m;
    valid = 1'b1;
    sof   = s;
    grey  = px[7:0];
    if (s) begin
      mcol = 0;
      mrow = 0;
    end
    img[mrow][mcol] = px & 255;
    m = 8'(ref_mag(mrow, mcol));
    e.mag = m;
`ifdef SOBEL_BIN_EN
    e.edge_bin = (m > thresh);
    e.grey     = e.edge_bin ? 16'hFFFF : 16'h0000;
`else
    e.edge_bin = 1'b0;
    e.grey     = {m[7:3], m[7:2], m[7:3]};
`endif
    e.sof    = s;
    e.pin_en = pin_en;
    e.pin    = pin[7:0];
    q.push_back(e);
    vin_hist[cyc] = 1'b1;
    mcol++;
    if (mcol == W) begin
      mcol = 0;
      mrow = (mrow == H - 1) ? 0 : mrow + 1;
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    sof   = 1'($urandom_range(0, 1));
    grey  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      valid = 1'b0;
      sof   = 1'($urandom_range(0, 1));
      grey  = 8'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_o_valid"}, o_valid, 0);
    check({tag, "_o_sof"}, o_sof, 0);
    check({tag, "_o_mag8b"}, o_mag8b, 0);
    check({tag, "_o_edge_bin"}, o_edge_bin, 0);
    check({tag, "_o_greydata"}, o_greydata, 0);
  endtask

  // Per-cycle compare: o_valid timing against the input log, data against the model queue.
  always @(negedge clk) begin
    bit   ev;
    exp_t e;
    if (chk_en) begin
      ev = (cyc >= 3) ? vin_hist[cyc-3] : 1'b0;
      check("o_valid_timing", o_valid, ev);
      if (o_valid && ev) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL queue: output pixel with nothing expected (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          check("o_mag8b", o_mag8b, e.mag);
          check("o_edge_bin", o_edge_bin, e.edge_bin);
          check("o_greydata", o_greydata, e.grey);
          check("o_sof", o_sof, e.sof);
          if (e.pin_en) check("pin_mag", o_mag8b, e.pin);
        end
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Flat frame
    thresh = 8'd50;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) send(100, (r == 0 && c == 0), 1'b1, 0);
    idle(4);

    // Vertical step: only window cols 2-4 and 3-5 straddle the edge
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send((c < 4) ? 0 : 200, (r == 0 && c == 0), 1'b1,
             (r >= 2 && (c == 4 || c == 5)) ? 255 : 0);
    idle(4);

    // Ramp, continuous then every other cycle
    thresh = 8'd64;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(10 * c, (r == 0 && c == 0), 1'b1, (r >= 2 && c >= 2) ? 80 : 0);
    idle(4);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(10 * c, (r == 0 && c == 0), 1'b1, (r >= 2 && c >= 2) ? 80 : 0);
        idle(1);
      end
    idle(4);

    // Sof re-align on the 13th pixel; the following two lines must be zero
    for (int k = 0; k < 12; k++) send($urandom_range(0, 255), (k == 0), 1'b0, 0);
    for (int k = 0; k < H * W; k++)
      send($urandom_range(0, 255), (k == 0), (k / W) < 2, 0);
    idle(4);

    // Reset during row 3 with pixels in flight
    for (int k = 0; k < 3 * W + 3; k++) send(10 * (k % W), (k == 0), 1'b0, 0);
    rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    q.delete();
    for (int k = cyc - 5; k <= cyc + 5; k++) vin_hist[k] = 1'b0;
    mcol = 0;
    mrow = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(10 * c, (r == 0 && c == 0), 1'b1, (r >= 2 && c >= 2) ? 80 : 0);
    idle(4);

    // Random frames: noisy or smooth content, random gaps, occasional wrap without sof
    for (int f = 0; f < 16; f++) begin
      bit noisy, use_sof;
      thresh  = 8'($urandom);
      noisy   = 1'($urandom_range(0, 1));
      use_sof = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < H * W; k++) begin
        send(noisy ? $urandom_range(0, 255) : 120 + $urandom_range(0, 20),
             use_sof && (k == 0), 1'b0, 0);
        idle($urandom_range(0, 2));
      end
      idle(4);
    end

    idle(6);
    check("queue_drained", q.size(), 0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
